// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: hold on stall, bubble on flush or invalid load, x0 write suppression, saturating flush counter.
// Optional ID_EX_WB_BYPASS_EN: operand data captures MEM/WB writeback data when the writeback targets that source register.
module id_ex_pipe_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_RegWrite,
  input  logic              in_MemRead,
  input  logic              in_MemWrite,
  input  logic              in_MemtoReg,
  input  logic              in_ALUSrc,
  input  logic              in_Branch,
  input  logic [1:0]        in_ALUOp,
  input  logic              MEM_WB_RegWrite,
  input  logic [4:0]        MEM_WB_rd,
  input  logic [DATA_W-1:0] MEM_WB_data,
  output logic              ID_EX_valid,
  output logic [DATA_W-1:0] ID_EX_pc,
  output logic [DATA_W-1:0] ID_EX_rs1_data,
  output logic [DATA_W-1:0] ID_EX_rs2_data,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic [4:0]        ID_EX_rs1,
  output logic [4:0]        ID_EX_rs2,
  output logic [4:0]        ID_EX_rd,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemtoReg,
  output logic              ID_EX_ALUSrc,
  output logic              ID_EX_Branch,
  output logic [1:0]        ID_EX_ALUOp,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam int PW = 1 + 4*DATA_W + 15 + 6 + 2;

  logic [PW-1:0]     pay_q, pay_d, pay_in;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rs1_src, rs2_src;
  logic              load_zero, capture;

`ifdef ID_EX_WB_BYPASS_EN
  logic fwd_rs1, fwd_rs2;
  assign fwd_rs1 = MEM_WB_RegWrite && (MEM_WB_rd != 5'd0) && (MEM_WB_rd == in_rs1);
  assign fwd_rs2 = MEM_WB_RegWrite && (MEM_WB_rd != 5'd0) && (MEM_WB_rd == in_rs2);
  assign rs1_src = fwd_rs1 ? MEM_WB_data : in_rs1_data;
  assign rs2_src = fwd_rs2 ? MEM_WB_data : in_rs2_data;
`else
  logic unused_wb;
  assign unused_wb = ^{MEM_WB_RegWrite, MEM_WB_rd, MEM_WB_data};
  assign rs1_src   = in_rs1_data;
  assign rs2_src   = in_rs2_data;
`endif

  // A write to x0 must never reach writeback, so RegWrite is masked at capture.
  assign pay_in = {1'b1, in_pc, rs1_src, rs2_src, in_imm, in_rs1, in_rs2, in_rd,
                   in_RegWrite && (in_rd != 5'd0), in_MemRead, in_MemWrite,
                   in_MemtoReg, in_ALUSrc, in_Branch, in_ALUOp};

  assign load_zero = flush || (!stall && !in_valid);
  assign capture   = !flush && !stall && in_valid;

  always_comb begin
    pay_d = pay_q;
    cnt_d = cnt_q;
    if (load_zero) begin
      pay_d = '0;
    end else if (capture) begin
      pay_d = pay_in;
    end
    if (flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pay_q <= '0;
      cnt_q <= '0;
    end else begin
      pay_q <= pay_d;
      cnt_q <= cnt_d;
    end
  end

  assign {ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
          ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_RegWrite, ID_EX_MemRead,
          ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch,
          ID_EX_ALUOp} = pay_q;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, counter saturation sequence, then random traffic against a rule-level model.
// A narrow bubble counter is used so saturation is reachable in a few cycles.
module tb_id_ex_pipe_reg;

  localparam int DW = 64;
  localparam int CW = 4;

  typedef struct packed {
    logic          rst, stall, flush, valid;
    logic [DW-1:0] pc, d1, d2, imm;
    logic [4:0]    rs1, rs2, rd;
    logic          rw, mr, mw, m2r, as, br;
    logic [1:0]    op;
    logic          wbrw;
    logic [4:0]    wbrd;
    logic [DW-1:0] wbd;
  } in_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, d1, d2, imm;
    logic [4:0]    rs1, rs2, rd;
    logic          rw, mr, mw, m2r, as, br;
    logic [1:0]    op;
    logic [CW-1:0] cnt;
  } out_t;

  typedef struct {
    in_t           i;
    logic          valid;
    logic [DW-1:0] pc;
    logic [4:0]    rd;
    logic          rw;
    logic [DW-1:0] d1;
    logic [CW-1:0] cnt;
    string         name;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, stall, flush, in_valid;
  logic [DW-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm, MEM_WB_data;
  logic [4:0]    in_rs1, in_rs2, in_rd, MEM_WB_rd;
  logic          in_RegWrite, in_MemRead, in_MemWrite, in_MemtoReg, in_ALUSrc, in_Branch;
  logic [1:0]    in_ALUOp;
  logic          MEM_WB_RegWrite;
  logic          ID_EX_valid;
  logic [DW-1:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic [4:0]    ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic          ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch;
  logic [1:0]    ID_EX_ALUOp;
  logic [CW-1:0] bubble_count;

  id_ex_pipe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_RegWrite(in_RegWrite), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_MemtoReg(in_MemtoReg), .in_ALUSrc(in_ALUSrc), .in_Branch(in_Branch), .in_ALUOp(in_ALUOp),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_data(MEM_WB_data),
    .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data),
    .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_Branch(ID_EX_Branch),
    .ID_EX_ALUOp(ID_EX_ALUOp), .bubble_count(bubble_count)
  );

  out_t act;
  assign act = '{valid: ID_EX_valid, pc: ID_EX_pc, d1: ID_EX_rs1_data, d2: ID_EX_rs2_data,
                 imm: ID_EX_imm, rs1: ID_EX_rs1, rs2: ID_EX_rs2, rd: ID_EX_rd,
                 rw: ID_EX_RegWrite, mr: ID_EX_MemRead, mw: ID_EX_MemWrite,
                 m2r: ID_EX_MemtoReg, as: ID_EX_ALUSrc, br: ID_EX_Branch,
                 op: ID_EX_ALUOp, cnt: bubble_count};

  int   checks = 0;
  int   failures = 0;
  out_t mdl;
  row_t tbl[$];

  task automatic drive(input in_t x);
    reset = x.rst; stall = x.stall; flush = x.flush; in_valid = x.valid;
    in_pc = x.pc; in_rs1_data = x.d1; in_rs2_data = x.d2; in_imm = x.imm;
    in_rs1 = x.rs1; in_rs2 = x.rs2; in_rd = x.rd;
    in_RegWrite = x.rw; in_MemRead = x.mr; in_MemWrite = x.mw;
    in_MemtoReg = x.m2r; in_ALUSrc = x.as; in_Branch = x.br; in_ALUOp = x.op;
    MEM_WB_RegWrite = x.wbrw; MEM_WB_rd = x.wbrd; MEM_WB_data = x.wbd;
  endtask

  // Reference: what the execute stage should see after one clock with inputs x.
  function automatic out_t model_next(input out_t cur, input in_t x);
    out_t n = '0;
    if (x.rst) return '0;
    if (x.flush) begin
      n.cnt = (int'(cur.cnt) == (1 << CW) - 1) ? cur.cnt : cur.cnt + 1'b1;
      return n;
    end
    if (x.stall) return cur;
    n.cnt = cur.cnt;
    if (!x.valid) return n;
    n.valid = 1'b1; n.pc = x.pc; n.d1 = x.d1; n.d2 = x.d2; n.imm = x.imm;
    n.rs1 = x.rs1; n.rs2 = x.rs2; n.rd = x.rd;
    n.rw = x.rw && (x.rd != 0);
    n.mr = x.mr; n.mw = x.mw; n.m2r = x.m2r; n.as = x.as; n.br = x.br; n.op = x.op;
`ifdef ID_EX_WB_BYPASS_EN
    if (x.wbrw && x.wbrd != 0 && x.wbrd == x.rs1) n.d1 = x.wbd;
    if (x.wbrw && x.wbrd != 0 && x.wbrd == x.rs2) n.d2 = x.wbd;
`endif
    return n;
  endfunction

  task automatic step_check(input in_t x, input string name);
    drive(x);
    @(posedge clk);
    #1;
    mdl = model_next(mdl, x);
    checks++;
    if (act !== mdl) begin
      failures++;
      $display("FAIL %s: got=%h want=%h", name, act, mdl);
    end
  endtask

  task automatic add_row(input in_t i, input logic v, input logic [DW-1:0] pc, input logic [4:0] rd,
                         input logic rw, input logic [DW-1:0] d1, input logic [CW-1:0] cnt,
                         input string name);
    row_t r;
    r.i = i; r.valid = v; r.pc = pc; r.rd = rd; r.rw = rw; r.d1 = d1; r.cnt = cnt; r.name = name;
    tbl.push_back(r);
  endtask

  initial begin
    in_t b, x;
    logic [DW-1:0] byp_exp;
    mdl = '0;

    // reset with all inputs nonzero
    x = '1; x.rst = 1'b1;
    add_row(x, 0, 0, 0, 0, 0, 0, "reset");
    b = '0;
    b.valid = 1; b.pc = 64'h100; b.rs1 = 5; b.rs2 = 6; b.rd = 7; b.rw = 1; b.op = 2'b10;
    b.d1 = 64'h1111; b.d2 = 64'h2222; b.imm = 64'hFFFF_FFFF_FFFF_FFF0;
    add_row(b, 1, 64'h100, 7, 1, 64'h1111, 0, "load");
    x = b; x.pc = 64'h200; x.rd = 9; x.d1 = 64'h3333; x.mw = 1; x.stall = 1;
    add_row(x, 1, 64'h100, 7, 1, 64'h1111, 0, "stall1");
    add_row(x, 1, 64'h100, 7, 1, 64'h1111, 0, "stall2");
    add_row(x, 1, 64'h100, 7, 1, 64'h1111, 0, "stall3");
    x.stall = 0;
    add_row(x, 1, 64'h200, 9, 1, 64'h3333, 0, "release");
    x.stall = 1; x.flush = 1;
    add_row(x, 0, 0, 0, 0, 0, 1, "stall_flush");
    x = b; x.rd = 0; x.pc = 64'h300; x.mr = 1; x.mw = 1;
    add_row(x, 1, 64'h300, 0, 0, 64'h1111, 1, "x0_write");
    x = b; x.valid = 0;
    add_row(x, 0, 0, 0, 0, 0, 1, "invalid_load");
`ifdef ID_EX_WB_BYPASS_EN
    byp_exp = 64'h5555;
`else
    byp_exp = 64'hAAAA;
`endif
    x = b; x.rs1 = 3; x.d1 = 64'hAAAA; x.wbrw = 1; x.wbrd = 3; x.wbd = 64'h5555;
    add_row(x, 1, 64'h100, 7, 1, byp_exp, 1, "bypass_hit");
    x.wbrd = 0;
    add_row(x, 1, 64'h100, 7, 1, 64'hAAAA, 1, "bypass_x0");
    x = '1; x.rst = 1; x.stall = 1; x.flush = 1;
    add_row(x, 0, 0, 0, 0, 0, 0, "reset_beats_flush");

    foreach (tbl[k]) begin
      step_check(tbl[k].i, {"model_", tbl[k].name});
      checks++;
      if ({act.valid, act.pc, act.rd, act.rw, act.d1, act.cnt} !==
          {tbl[k].valid, tbl[k].pc, tbl[k].rd, tbl[k].rw, tbl[k].d1, tbl[k].cnt}) begin
        failures++;
        $display("FAIL %s: got valid=%0b pc=%h rd=%0d rw=%0b d1=%h cnt=%0d want valid=%0b pc=%h rd=%0d rw=%0b d1=%h cnt=%0d",
                 tbl[k].name, act.valid, act.pc, act.rd, act.rw, act.d1, act.cnt,
                 tbl[k].valid, tbl[k].pc, tbl[k].rd, tbl[k].rw, tbl[k].d1, tbl[k].cnt);
      end
    end

    // saturate the counter, then one more flush must not wrap
    x = b; x.flush = 1;
    for (int n = 0; n < (1 << CW) + 3; n++) step_check(x, "sat_flush");
    checks++;
    if (bubble_count !== {CW{1'b1}}) begin
      failures++;
      $display("FAIL saturate: got=%0d want=%0d", bubble_count, (1 << CW) - 1);
    end
    x = b;
    step_check(x, "sat_then_load");
    checks++;
    if (bubble_count !== {CW{1'b1}} || ID_EX_pc !== 64'h100) begin
      failures++;
      $display("FAIL sat_hold: got cnt=%0d pc=%h want cnt=%0d pc=100", bubble_count, ID_EX_pc, (1 << CW) - 1);
    end

    for (int n = 0; n < 3000; n++) begin
      x.rst   = ($urandom_range(99) == 0);
      x.flush = ($urandom_range(9) == 0);
      x.stall = ($urandom_range(3) == 0);
      x.valid = ($urandom_range(3) != 0);
      x.pc  = {$urandom, $urandom}; x.d1 = {$urandom, $urandom};
      x.d2  = {$urandom, $urandom}; x.imm = {$urandom, $urandom};
      x.rs1 = 5'($urandom_range(7)); x.rs2 = 5'($urandom_range(7));
      x.rd  = 5'($urandom_range(3));
      {x.rw, x.mr, x.mw, x.m2r, x.as, x.br, x.op} = 8'($urandom);
      x.wbrw = 1'($urandom); x.wbrd = 5'($urandom_range(7)); x.wbd = {$urandom, $urandom};
      step_check(x, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
